// File: rtl/seg7_output_stage.sv
// 7-segment output stage: PWM brightness, blink, polarity and registered pin drive.
// Optional macro SEG7_OUT_FADE_EN adds a per-pattern fade-in ramp of the duty level.
module seg7_output_stage #(
  parameter int PWM_BITS       = 4,
  parameter int BLINK_DIV_BITS = 22,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                dp_in,
  input  logic                seg_valid,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink_en,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic                frame_start
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [7:0]          IDLE = {8{ACTIVE_LOW}};

  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [BLINK_DIV_BITS-1:0] blink_cnt;
  logic                      blink_phase;
  logic [7:0]                pending;
  logic                      pend_flag;
  logic [7:0]                shown;
  logic [PWM_BITS-1:0]       bright_q;
  logic                      wrap;
  logic [PWM_BITS-1:0]       duty_lvl_p0;
  logic                      on_p0;
  logic                      blank_p0;
  logic [7:0]                drive_p0;

  function automatic logic duty_on(input logic [PWM_BITS-1:0] cnt,
                                   input logic [PWM_BITS-1:0] lvl);
    duty_on = (lvl == MAX) || (cnt < lvl);
  endfunction

  assign wrap = (pwm_cnt == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (blink_cnt == '1)
        blink_phase <= ~blink_phase;
    end
  end

  // Capture: the latest strobe in a period wins; a strobe on the wrap edge bypasses pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (seg_valid)
        pending <= {dp_in, seg_in};
      if (wrap)
        pend_flag <= 1'b0;
      else if (seg_valid)
        pend_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown    <= '0;
      bright_q <= '0;
    end else if (wrap) begin
      bright_q <= brightness;
      if (seg_valid)
        shown <= {dp_in, seg_in};
      else if (pend_flag)
        shown <= pending;
    end
  end

`ifdef SEG7_OUT_FADE_EN
  logic [PWM_BITS-1:0] fade_lvl;
  logic                commit_new;

  // One step up the ramp, saturating at the (possibly lowered) brightness ceiling.
  function automatic logic [PWM_BITS-1:0] fade_step(input logic [PWM_BITS-1:0] lvl,
                                                    input logic [PWM_BITS-1:0] ceil);
    logic [PWM_BITS:0] inc;
    inc = {1'b0, lvl} + {{PWM_BITS{1'b0}}, 1'b1};
    if (inc > {1'b0, ceil})
      fade_step = ceil;
    else
      fade_step = inc[PWM_BITS-1:0];
  endfunction

  assign commit_new = wrap & (seg_valid | pend_flag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fade_lvl <= '0;
    else if (commit_new)
      fade_lvl <= '0;
    else if (wrap)
      fade_lvl <= fade_step(fade_lvl, bright_q);
  end

  assign duty_lvl_p0 = fade_lvl;
`else
  assign duty_lvl_p0 = bright_q;
`endif

  // Stage p0: duty and blink gating of the shown pattern.
  assign on_p0    = duty_on(pwm_cnt, duty_lvl_p0);
  assign blank_p0 = blink_en & blink_phase;
  assign drive_p0 = (on_p0 & ~blank_p0) ? shown : 8'h00;

  // Stage p1: registered pin drive with polarity applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {dp_out, seg_out} <= IDLE;
      frame_start       <= 1'b0;
    end else begin
      {dp_out, seg_out} <= drive_p0 ^ IDLE;
      frame_start       <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_output_stage.sv
// Bench for seg7_output_stage: directed steps plus random traffic against a time-indexed model.
module tb_seg7_output_stage;

  localparam int PB = 4;
  localparam int BB = 4;
  localparam int PERIOD = 1 << PB;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic        seg_valid;
  logic [3:0]  brightness;
  logic        blink_en;
  logic [6:0]  seg_out, seg_out_al;
  logic        dp_out, dp_out_al;
  logic        frame_start, frame_start_al;

  always #5 clk = ~clk;

  seg7_output_stage #(.PWM_BITS(PB), .BLINK_DIV_BITS(BB), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in), .seg_valid(seg_valid),
    .brightness(brightness), .blink_en(blink_en), .seg_out(seg_out), .dp_out(dp_out),
    .frame_start(frame_start));

  seg7_output_stage #(.PWM_BITS(PB), .BLINK_DIV_BITS(BB), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in), .seg_valid(seg_valid),
    .brightness(brightness), .blink_en(blink_en), .seg_out(seg_out_al), .dp_out(dp_out_al),
    .frame_start(frame_start_al));

  int errors = 0;
  int checks = 0;

  // Model state: t counts clocks since reset release, so pwm = t mod 16, blink half = t / 16.
  int unsigned t;
  logic [7:0]  m_shown, m_pend;
  logic        m_pflag;
  logic [3:0]  m_bright, m_fade;
  logic [7:0]  exp_drive;
  logic        exp_fs;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_shown = '0; m_pend = '0; m_pflag = 1'b0; m_bright = '0; m_fade = '0;
  endtask

  task automatic chk_reset_state();
    chk8("reset_seg_dp", {dp_out, seg_out}, 8'h00);
    chk8("reset_frame_start", {7'b0, frame_start}, 8'h00);
    chk8("reset_seg_dp_al", {dp_out_al, seg_out_al}, 8'hFF);
    chk8("reset_frame_start_al", {7'b0, frame_start_al}, 8'h00);
  endtask

  task automatic tick();
    int         pwm;
    int         nf;
    logic       blank, on;
    logic [3:0] lvl;
    pwm   = int'(t % PERIOD);
    blank = blink_en && (((t >> BB) & 1) == 1);
`ifdef SEG7_OUT_FADE_EN
    lvl = m_fade;
`else
    lvl = m_bright;
`endif
    on        = (lvl == 4'hF) || (pwm < int'(lvl));
    exp_drive = (on && !blank) ? m_shown : 8'h00;
    exp_fs    = (pwm == PERIOD - 1);
    if (pwm == PERIOD - 1) begin
      nf = int'(m_fade) + 1;
      if (seg_valid || m_pflag) m_fade = 4'h0;
      else m_fade = (nf > int'(m_bright)) ? m_bright : 4'(nf);
      if (seg_valid) m_shown = {dp_in, seg_in};
      else if (m_pflag) m_shown = m_pend;
      m_pflag  = 1'b0;
      m_bright = brightness;
    end else if (seg_valid) begin
      m_pflag = 1'b1;
    end
    if (seg_valid) m_pend = {dp_in, seg_in};
    t++;
    @(posedge clk);
    #1;
    chk8("seg_dp", {dp_out, seg_out}, exp_drive);
    chk8("frame_start", {7'b0, frame_start}, {7'b0, exp_fs});
    chk8("seg_dp_al", {dp_out_al, seg_out_al}, ~exp_drive);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic advance_to(input int p);
    while (int'(t % PERIOD) != p) tick();
  endtask

  task automatic strobe(input logic [6:0] pat, input logic dp);
    seg_in = pat; dp_in = dp; seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic count_on(input string tag, input int expected);
    int cnt;
    cnt = 0;
    repeat (PERIOD) begin
      tick();
      if ({dp_out, seg_out} != 8'h00) cnt++;
    end
    chk8(tag, 8'(cnt), 8'(expected));
  endtask

  initial begin
    reset = 1'b1; seg_in = '0; dp_in = 1'b0; seg_valid = 1'b0; brightness = '0; blink_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    reset = 1'b0;
    model_reset();

    // Old pattern, then 7'h3F strobed mid-period at full brightness.
    brightness = 4'hF;
    strobe(7'h06, 1'b1);
    advance_to(5);
    strobe(7'h3F, 1'b0);
    run(40);

    // Partial duty, then off.
    brightness = 4'h4;
    run(64);
    count_on("on_time_b4", 4);
    brightness = 4'h0;
    run(48);
    count_on("on_time_b0", 0);

    // Last strobe wins; strobe on the wrap edge is shown directly.
    brightness = 4'hF;
    run(32);
    advance_to(2);
    strobe(7'h06, 1'b0);
    run(3);
    strobe(7'h5B, 1'b0);
    run(20);
    advance_to(15);
    strobe(7'h66, 1'b1);
    run(20);

    // Blink.
    blink_en = 1'b1;
    run(64);
    blink_en = 1'b0;
    run(32);

    // New pattern at brightness 4: ramp when fading, flat otherwise.
    brightness = 4'h4;
    run(32);
    advance_to(8);
    strobe(7'h7F, 1'b1);
    advance_to(0);
    for (int k = 0; k < 6; k++) begin
`ifdef SEG7_OUT_FADE_EN
      count_on("fade_on_time", (k < 4) ? k : 4);
`else
      count_on("steady_on_time", 4);
`endif
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      seg_valid = ($urandom_range(0, 5) == 0);
      seg_in    = 7'($urandom);
      dp_in     = 1'($urandom);
      if ($urandom_range(0, 40) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 60) == 0) blink_en = ~blink_en;
      tick();
    end
    seg_valid = 1'b0;

    // Reset mid-frame with a pending pattern: it must never appear.
    blink_en = 1'b0;
    brightness = 4'hF;
    advance_to(3);
    strobe(7'h49, 1'b1);
    run(3);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state();
    @(posedge clk);
    #1;
    chk_reset_state();
    reset = 1'b0;
    model_reset();
    run(48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
